// File: rtl/led_chaser_if.sv
// Control/status bundle for led_chaser: run, direction, pattern mode and polarity
// in; registered LED drive and step pulse out.
interface led_chaser_if #(
   parameter int N = 4
);
   logic         EN;
   logic         DIR;
   logic [1:0]   MODE;
   logic         SW;
   logic [N-1:0] LED;
   logic         STEP;

   modport master (output EN, DIR, MODE, SW, input LED, STEP);
   modport slave  (input EN, DIR, MODE, SW, output LED, STEP);
endinterface

// File: rtl/led_chaser.sv
// Running-light generator: prescaled step tick drives dot / fill / bounce patterns
// on N LEDs. Bounce mode exists only when LED_CHASER_BOUNCE_EN is defined.
module led_chaser #(
   parameter int N   = 4,
   parameter int DIV = 5000000,
   parameter int CW  = 32
) (
   input  logic       CLK,
   input  logic       RST,
   led_chaser_if.slave ctl
);
   localparam int PW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [PW-1:0] POS_LAST = PW'(N - 1);

   typedef enum logic [1:0] {
      MODE_DOT    = 2'b00,
      MODE_FILL   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_RSV    = 2'b11
   } mode_t;

   mode_t         mode_q;
   mode_t         mode_in;
   logic [CW-1:0] cnt, cnt_d;
   logic [PW-1:0] pos, pos_d;
   logic [N-1:0]  base, pat, led_d;
   logic          step_d;
   logic          tick;
   logic          restart;
   logic          fill;

`ifdef LED_CHASER_BOUNCE_EN
   typedef enum logic {SWEEP_DN = 1'b0, SWEEP_UP = 1'b1} sweep_t;
   sweep_t up, up_d;
   logic   bounce;
`endif

   assign mode_in = mode_t'(ctl.MODE);

   // Reserved encoding falls through to dot; it still differs from mode_q for restart.
   always_comb begin
      fill = 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
      bounce = 1'b0;
`endif
      case (mode_q)
         MODE_FILL:   fill = 1'b1;
`ifdef LED_CHASER_BOUNCE_EN
         MODE_BOUNCE: bounce = 1'b1;
`endif
         default:     ;
      endcase
   end

   always_comb begin
      base = '0;
      pat  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         base[i] = fill ? (i <= 32'(pos)) : (i == 32'(pos));
      end
      for (int unsigned i = 0; i < N; i++) begin
         pat[i] = ctl.DIR ? base[i] : base[N-1-i];
      end
   end

   always_comb begin
      cnt_d   = cnt;
      pos_d   = pos;
      step_d  = 1'b0;
      led_d   = ctl.SW ? pat : ~pat;
      tick    = ctl.EN && (cnt == CNT_LAST);
      restart = (mode_in != mode_q);
`ifdef LED_CHASER_BOUNCE_EN
      up_d    = up;
`endif
      if (restart) begin
         cnt_d = '0;
         pos_d = '0;
`ifdef LED_CHASER_BOUNCE_EN
         up_d  = SWEEP_UP;
`endif
      end else if (tick) begin
         cnt_d  = '0;
         step_d = 1'b1;
         pos_d  = (pos == POS_LAST) ? '0 : pos + 1'b1;
`ifdef LED_CHASER_BOUNCE_EN
         // Turn around on the step that reaches an endpoint so each end shows once.
         if (bounce) begin
            if (up == SWEEP_UP) begin
               pos_d = pos + 1'b1;
               if (pos == POS_LAST - 1'b1) up_d = SWEEP_DN;
            end else begin
               pos_d = pos - 1'b1;
               if (pos == PW'(1)) up_d = SWEEP_UP;
            end
         end
`endif
      end else if (ctl.EN) begin
         cnt_d = cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt      <= '0;
         pos      <= '0;
         mode_q   <= MODE_DOT;
         ctl.LED  <= '0;
         ctl.STEP <= 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
         up       <= SWEEP_UP;
`endif
      end else begin
         cnt      <= cnt_d;
         pos      <= pos_d;
         mode_q   <= mode_in;
         ctl.LED  <= led_d;
         ctl.STEP <= step_d;
`ifdef LED_CHASER_BOUNCE_EN
         up       <= up_d;
`endif
      end
   end
endmodule
